// File: rtl/dm_ctrl.sv
// Data memory behind the pointer-to-address lookup stage: single-port register file
// with one-cycle registered loads and a hardware zeroing sweep after reset or on clear.
module dm_ctrl #(
   parameter int AW    = 8,
   parameter int DW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] dm_adr,
   input  logic [DW-1:0] din,
   input  logic          clear,
   output logic          ready,
   output logic [DW-1:0] dout,
   output logic          rd_valid,
   output logic          adr_err
);

   // Counter is one bit wider than the address so DEPTH = 2**AW compares without wrapping.
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] LAST_C  = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t        state_r;
   logic [AW:0]   cnt_r;
   logic [DW-1:0] mem_r [DEPTH];
   logic          ready_r;
   logic          rd_valid_r;
   logic          adr_err_r;
   logic [DW-1:0] dout_r;

   logic          accept_s;
   logic          in_range_s;
   logic          mem_we_s;
   logic [AW-1:0] mem_wa_s;
   logic [DW-1:0] mem_wd_s;

   // Accept qualification and array write-port selection (sweep wins over stores).
   always_comb begin
      in_range_s = ({1'b0, dm_adr} < DEPTH_C);
      accept_s   = ready_r & req & ~clear;
      mem_we_s   = 1'b0;
      mem_wa_s   = cnt_r[AW-1:0];
      mem_wd_s   = {DW{1'b0}};
      if (reset) begin
         mem_we_s = 1'b0;
      end else if (state_r == ST_CLEAR) begin
         mem_we_s = 1'b1;
         mem_wa_s = cnt_r[AW-1:0];
         mem_wd_s = {DW{1'b0}};
      end else if (accept_s && we && in_range_s) begin
         mem_we_s = 1'b1;
         mem_wa_s = dm_adr;
         mem_wd_s = din;
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Storage array: plain synchronous write, never reset.
   always_ff @(posedge CLK) begin
      if (mem_we_s) begin
         mem_r[mem_wa_s] <= mem_wd_s;
      end
   end

   // Sweep/idle FSM with registered handshake and load-return outputs.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_r    <= ST_CLEAR;
         cnt_r      <= {(AW+1){1'b0}};
         ready_r    <= 1'b0;
         rd_valid_r <= 1'b0;
         adr_err_r  <= 1'b0;
         dout_r     <= {DW{1'b0}};
      end else begin
         rd_valid_r <= 1'b0;
         adr_err_r  <= 1'b0;
         case (state_r)
            ST_CLEAR: begin
               if (cnt_r == LAST_C) begin
                  state_r <= ST_IDLE;
                  ready_r <= 1'b1;
                  cnt_r   <= {(AW+1){1'b0}};
               end else begin
                  cnt_r <= cnt_r + ONE_C;
               end
            end
            ST_IDLE: begin
               if (clear) begin
                  state_r <= ST_CLEAR;
                  ready_r <= 1'b0;
                  cnt_r   <= {(AW+1){1'b0}};
               end else if (accept_s) begin
                  adr_err_r <= ~in_range_s;
                  if (!we) begin
                     rd_valid_r <= 1'b1;
                     dout_r     <= in_range_s ? mem_r[dm_adr] : {DW{1'b0}};
                  end
               end
            end
            default: begin
               state_r <= ST_CLEAR;
               ready_r <= 1'b0;
               cnt_r   <= {(AW+1){1'b0}};
            end
         endcase
      end
   end

   assign ready    = ready_r;
   assign dout     = dout_r;
   assign rd_valid = rd_valid_r;
   assign adr_err  = adr_err_r;

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Data memory block fed directly by the pointer-to-address lookup stage.
- Accepts load/store requests addressed by the 8-bit dm_adr that stage produces.
- Holds a DEPTH x DW storage array and returns load data with one-cycle registered latency.
- Runs a hardware clear sweep after reset, and on demand, that zeroes every location before normal accesses are accepted.

Parameters:
AW, 8, address width; matches the dm_adr width produced by the lookup stage
DW, 8, data word width
DEPTH, 256, number of implemented locations; 1 <= DEPTH <= 2**AW

Ports:
CLK  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request; qualified by ready
we  input  1  1 = store, 0 = load; sampled with req
dm_adr  input  AW  location address from the lookup stage
din  input  DW  store data
clear  input  1  start a clear sweep; honoured only in IDLE
ready  output  1  1 = block accepts req this cycle
dout  output  DW  load data; valid when rd_valid = 1
rd_valid  output  1  one-cycle pulse, load data present on dout
adr_err  output  1  one-cycle pulse, accepted request had dm_adr >= DEPTH

Behaviour:
- Reset (asynchronous, active-high):
  - ready=0, rd_valid=0, adr_err=0, dout=0.
  - State=CLEAR, sweep counter=0.
  - Array contents are not touched asynchronously; the sweep zeroes them.
- States:
  - CLEAR: writes 0 to location cnt each cycle, then cnt++. ready=0.
    - When cnt == DEPTH-1 has been written, go to IDLE next cycle.
    - The sweep takes exactly DEPTH cycles after reset deasserts.
  - IDLE: ready=1.
    - clear=1 enters CLEAR with cnt=0. clear has priority over a coincident req, which is not accepted.
- Accept rule: a request is accepted on a rising edge where ready=1 and req=1 and clear=0.
  - req while ready=0 is ignored. The requester holds req until it is accepted.
- Store, accepted with dm_adr < DEPTH: mem[dm_adr] <= din at that edge.
  - rd_valid stays 0. ready stays 1, so back-to-back stores are allowed.
- Load, accepted with dm_adr < DEPTH: dout <= mem[dm_adr] at that edge.
  - rd_valid=1 for the following cycle only.
  - Loads are pipelined: one load per cycle, each returning one cycle later.
  - dout holds its last value when rd_valid=0.
- Read-after-write: a load accepted in the cycle after a store to the same address returns the new data. Same-cycle load and store cannot occur (single port).
- Out of range, dm_adr >= DEPTH:
  - Request is still accepted (consumes the cycle).
  - No array write. For a load, dout=0 and rd_valid=1.
  - adr_err=1 for the following cycle.
  - When DEPTH = 2**AW, adr_err is never set.
- Counter width is AW+1 bits, so the counter compares cleanly against DEPTH = 2**AW with no wrap.
- Reset mid-sweep or mid-load:
  - Any pending rd_valid/adr_err pulse is squashed.
  - The sweep restarts from 0 when reset deasserts.
- clear while in CLEAR: ignored; the sweep continues from its current cnt.
- The array is a plain synchronous-write register file. No byte enables, no wait states.

Test Plan:
- Reset pulse, then deassert -> ready=0 for exactly 256 cycles (DEPTH=256), then ready=1. A load of each address 0, 1, 127 and 255 returns 8'h00 with rd_valid=1 one cycle after accept.
- Stores of 8'hA5 to addr 3, 8'h5A to addr 4, then loads of 3 and 4 back-to-back -> dout=8'hA5 then 8'h5A on consecutive cycles, rd_valid high both cycles.
- Store 8'h3C to addr 5, then load addr 5 on the very next cycle -> dout=8'h3C one cycle later, confirming read-after-write.
- DEPTH=200 build, load addr 8'd210 -> next cycle rd_valid=1, dout=8'h00, adr_err=1. A store of 8'hFF to addr 210 leaves addrs 0..199 unchanged and pulses adr_err.
- In IDLE after storing 8'h77 to addr 9, assert clear together with req(load, addr 9):
  - req is not accepted, and ready=0 for DEPTH cycles.
  - After the sweep, a load of addr 9 returns 8'h00.
- Assert reset while cnt=100 mid-sweep and again one cycle after a load is accepted -> rd_valid stays 0, and ready returns only after a full DEPTH-cycle sweep.
